// File: rtl/blctrl_frame_scheduler.sv
// Frame scheduler driving one I2C master across NUM_MOTORS BL-Ctrl ESCs.
// Optional per-motor slew limiting is enabled by defining BLCTRL_SCHED_SLEW_EN.
module blctrl_frame_scheduler #(
   parameter int unsigned NUM_MOTORS  = 8,
   parameter logic [6:0]  BASE_ADDR   = 7'h29,
   parameter int unsigned WDOG_FRAMES = 100,
   parameter int unsigned MAX_RETRY   = 2,
`ifdef BLCTRL_SCHED_SLEW_EN
   parameter int unsigned SLEW_STEP   = 8,
`endif
   parameter int unsigned FRAME_TICKS = 16000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      masterEnable,
   input  logic [NUM_MOTORS-1:0]     motorEnable,
   input  logic [8*NUM_MOTORS-1:0]   targetSpeedFlat,
   input  logic                      speedStrobe,
   output logic                      cmdValid,
   input  logic                      cmdReady,
   output logic [6:0]                cmdAddr,
   output logic [7:0]                cmdData,
   input  logic                      xferDone,
   input  logic                      xferNack,
   output logic                      busy,
   output logic                      frameDone,
   output logic [NUM_MOTORS-1:0]     nackFlags,
   output logic                      failsafe
);
   localparam int unsigned IW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
   localparam int unsigned TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam int unsigned WW = $clog2(WDOG_FRAMES + 1);
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_e;
   state_e state_q, state_d;

   logic [TW-1:0]              tmr_q, tmr_d;
   logic                       pend_q, pend_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [RW-1:0]              retry_q, retry_d;
   logic [NUM_MOTORS-1:0][7:0] snap_q, snap_d;
   logic [NUM_MOTORS-1:0]      en_q, en_d;
   logic [NUM_MOTORS-1:0]      nack_q, nack_d;
   logic                       fs_snap_q, fs_snap_d;
   logic [WW-1:0]              wd_q, wd_d;
   logic                       tick, start, last_motor, ack, nack, retry_ok;
   logic [7:0]                 wr_data;

   assign tick       = (tmr_q == TW'(FRAME_TICKS - 1));
   assign start      = masterEnable & (tick | pend_q);
   assign last_motor = (idx_q == IW'(NUM_MOTORS - 1));
   assign ack        = xferDone & ~xferNack;
   assign nack       = xferDone & xferNack;
   assign retry_ok   = (retry_q < RW'(MAX_RETRY));
   assign failsafe   = (wd_q == WW'(WDOG_FRAMES));
   assign nackFlags  = nack_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  state_d = S_ISSUE;
         S_ISSUE: if (cmdReady) state_d = S_WAIT;
         S_WAIT: begin
            if (nack && retry_ok) state_d = S_ISSUE;
            else if (xferDone)    state_d = S_NEXT;
         end
         // Losing masterEnable ends the frame silently once the current motor is handled.
         S_NEXT: begin
            if (!masterEnable)   state_d = S_IDLE;
            else if (last_motor) state_d = S_DONE;
            else                 state_d = S_ISSUE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmdValid  = 1'b0;
      cmdAddr   = '0;
      cmdData   = '0;
      busy      = (state_q != S_IDLE);
      frameDone = (state_q == S_DONE);
      if (state_q == S_ISSUE) begin
         cmdValid = 1'b1;
         cmdAddr  = BASE_ADDR + 7'(idx_q);
         cmdData  = wr_data;
      end
   end

   always_comb begin
      tmr_d     = tick ? '0 : tmr_q + 1'b1;
      pend_d    = pend_q;
      idx_d     = idx_q;
      retry_d   = retry_q;
      snap_d    = snap_q;
      en_d      = en_q;
      fs_snap_d = fs_snap_q;
      nack_d    = nack_q;
      wd_d      = wd_q;
      if (!masterEnable || state_q == S_IDLE) pend_d = 1'b0;
      else if (tick)                          pend_d = 1'b1;
      case (state_q)
         S_LOAD: begin
            snap_d    = targetSpeedFlat;
            en_d      = motorEnable;
            fs_snap_d = failsafe;
            idx_d     = '0;
            retry_d   = '0;
         end
         S_WAIT: begin
            if (nack && retry_ok) retry_d = retry_q + 1'b1;
            else if (ack)         nack_d[idx_q] = 1'b0;
            else if (nack)        nack_d[idx_q] = 1'b1;
         end
         S_NEXT: begin
            if (masterEnable && !last_motor) begin
               idx_d   = idx_q + 1'b1;
               retry_d = '0;
            end
         end
         default: ;
      endcase
      if (speedStrobe)                        wd_d = '0;
      else if (state_q == S_DONE && !failsafe) wd_d = wd_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_q     <= '0;
         pend_q    <= 1'b0;
         idx_q     <= '0;
         retry_q   <= '0;
         snap_q    <= '0;
         en_q      <= '0;
         fs_snap_q <= 1'b0;
         nack_q    <= '0;
         wd_q      <= '0;
      end else begin
         tmr_q     <= tmr_d;
         pend_q    <= pend_d;
         idx_q     <= idx_d;
         retry_q   <= retry_d;
         snap_q    <= snap_d;
         en_q      <= en_d;
         fs_snap_q <= fs_snap_d;
         nack_q    <= nack_d;
         wd_q      <= wd_d;
      end
   end

`ifdef BLCTRL_SCHED_SLEW_EN
   localparam logic [8:0] STEP = 9'(SLEW_STEP);
   logic [NUM_MOTORS-1:0][7:0] last_q, last_d;
   logic [8:0]                 tgt, cur;
   logic                       bypass;

   // Data stays stable across retries because last only moves when the motor is finished.
   always_comb begin
      bypass = fs_snap_q | ~en_q[idx_q];
      tgt    = {1'b0, snap_q[idx_q]};
      cur    = {1'b0, last_q[idx_q]};
      if (bypass)                wr_data = '0;
      else if (tgt > cur + STEP) wr_data = 8'(cur + STEP);
      else if (tgt + STEP < cur) wr_data = 8'(cur - STEP);
      else                       wr_data = tgt[7:0];
      last_d = last_q;
      if (state_q == S_WAIT && xferDone && (bypass || ack)) last_d[idx_q] = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= '0;
      else        last_q <= last_d;
   end
`else
   assign wr_data = (fs_snap_q || !en_q[idx_q]) ? 8'h00 : snap_q[idx_q];
`endif

endmodule

// File: tb/tb_blctrl_frame_scheduler.sv
// Directed bench for blctrl_frame_scheduler with a behavioural I2C master responder.
// Defining BLCTRL_SCHED_SLEW_EN selects the slew-limiting scenario instead of the default set.
module tb_blctrl_frame_scheduler;
   localparam int unsigned FT = 64;
   localparam int unsigned WD = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        masterEnable = 1'b0;
   logic [7:0]  motorEnable = 8'hFF;
   logic [63:0] targetSpeedFlat = {8{8'h80}};
   logic        speedStrobe = 1'b0;
   logic        cmdValid, cmdReady = 1'b1;
   logic [6:0]  cmdAddr;
   logic [7:0]  cmdData;
   logic        xferDone = 1'b0, xferNack = 1'b0;
   logic        busy, frameDone, failsafe;
   logic [7:0]  nackFlags;

   blctrl_frame_scheduler #(.NUM_MOTORS(8), .BASE_ADDR(7'h29), .WDOG_FRAMES(WD),
                            .MAX_RETRY(2), .FRAME_TICKS(FT)) dut (
      .clk(clk), .rst_n(rst_n), .masterEnable(masterEnable), .motorEnable(motorEnable),
      .targetSpeedFlat(targetSpeedFlat), .speedStrobe(speedStrobe), .cmdValid(cmdValid),
      .cmdReady(cmdReady), .cmdAddr(cmdAddr), .cmdData(cmdData), .xferDone(xferDone),
      .xferNack(xferNack), .busy(busy), .frameDone(frameDone), .nackFlags(nackFlags),
      .failsafe(failsafe));

   always #5 clk = ~clk;

   int unsigned n_checks = 0, n_errors = 0;
   int unsigned cyc = 0;
   logic [7:0]  nack_mask = '0;
   int unsigned stall_left = 0;
   int unsigned xfer_cnt = 0;
   logic        xfer_nack = 1'b0;
   logic [6:0]  log_addr[$];
   logic [7:0]  log_data[$];

   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Responder: accepts requests, stalls on motor 7 when asked, reports done 2 cycles later.
   always @(negedge clk) begin
      xferDone = 1'b0;
      xferNack = 1'b0;
      if (!rst_n) begin
         xfer_cnt = 0;
         cmdReady = 1'b1;
      end else begin
         if (xfer_cnt != 0) begin
            xfer_cnt--;
            if (xfer_cnt == 0) begin
               xferDone = 1'b1;
               xferNack = xfer_nack;
            end
         end
         cmdReady = !(cmdValid && cmdAddr == 7'h30 && stall_left != 0);
         if (!cmdReady) stall_left--;
         if (cmdValid && cmdReady) begin
            log_addr.push_back(cmdAddr);
            log_data.push_back(cmdData);
            xfer_cnt  = 2;
            xfer_nack = nack_mask[3'(cmdAddr - 7'h29)];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic log_clear();
      log_addr.delete();
      log_data.delete();
   endtask

   task automatic wait_frame_done(input string tag);
      int unsigned n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frameDone && n < 400);
      if (!frameDone) check_eq({tag, "_timeout"}, 32'(frameDone), 1);
   endtask

   task automatic wait_valid(input string tag, input logic [6:0] addr);
      int unsigned n = 0;
      while (!(cmdValid && cmdAddr == addr) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!(cmdValid && cmdAddr == addr)) check_eq({tag, "_timeout"}, 32'(cmdAddr), 32'(addr));
   endtask

   task automatic strobe();
      speedStrobe = 1'b1;
      @(negedge clk);
      speedStrobe = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [7:0] exp);
      int unsigned ok = 0;
      check_eq({tag, "_count"}, log_addr.size(), 8);
      for (int i = 0; i < log_addr.size() && i < 8; i++)
         if (log_addr[i] == 7'(7'h29 + i) && log_data[i] == exp) ok++;
      check_eq({tag, "_writes"}, ok, 8);
   endtask

   initial begin
      int unsigned fd1, n, fr;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 32'(cmdValid), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(frameDone), 0);
      check_eq("rst_nack", 32'(nackFlags), 0);
      check_eq("rst_fs", 32'(failsafe), 0);
      check_eq("rst_addr", 32'(cmdAddr), 0);
      rst_n = 1'b1;
      masterEnable = 1'b1;
      log_clear();
`ifdef BLCTRL_SCHED_SLEW_EN
      for (int f = 1; f <= 16; f++) begin
         wait_frame_done("slew_up");
         check_frame("slew_up", 8'(8 * f));
         strobe();
         log_clear();
      end
      targetSpeedFlat = {8{8'd200}};
      for (int s = 1; s <= 9; s++) begin
         wait_frame_done("slew_200");
         check_frame("slew_200", 8'(128 + 8 * s));
         strobe();
         log_clear();
      end
      for (int f = 0; f < 4; f++) wait_frame_done("slew_wd");
      @(negedge clk);
      check_eq("slew_fs", 32'(failsafe), 1);
      log_clear();
      wait_frame_done("slew_fs0");
      check_frame("slew_fs0", 8'h00);
      strobe();
      log_clear();
      wait_frame_done("slew_restart");
      check_frame("slew_restart", 8'd8);
`else
      // 1) steady frames: latency, data, period
      wait_valid("lat", 7'h29);
      check_eq("latency", cyc, FT + 1);
      wait_frame_done("t1a");
      fd1 = cyc;
      check_frame("t1", 8'h80);
      check_eq("t1_nack", 32'(nackFlags), 0);
      strobe();
      check_eq("t1_busy_idle", 32'(busy), 0);
      wait_frame_done("t1b");
      check_eq("t1_period", cyc - fd1, FT);
      strobe();
      // 2) motor 3 always NACKs
      nack_mask = 8'h08;
      log_clear();
      wait_frame_done("t2");
      check_eq("t2_count", log_addr.size(), 10);
      n = 0;
      for (int i = 0; i < log_addr.size(); i++) if (log_addr[i] == 7'h2C) n++;
      check_eq("t2_m3_writes", n, 3);
      if (log_addr.size() > 6) check_eq("t2_after", 32'(log_addr[6]), 32'h2D);
      check_eq("t2_flags", 32'(nackFlags), 32'h08);
      strobe();
      nack_mask = '0;
      log_clear();
      wait_frame_done("t2c");
      check_eq("t2_cleared", 32'(nackFlags), 0);
      check_frame("t2c", 8'h80);
      strobe();
      // 3) stall on motor 7 across a tick
      stall_left = 50;
      log_clear();
      wait_valid("t3", 7'h30);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         if (i != 0) @(negedge clk);
         if (cmdValid && cmdAddr == 7'h30 && cmdData == 8'h80) n++;
      end
      check_eq("t3_stable", n, 50);
      @(negedge clk);
      check_eq("t3_hs_valid", 32'(cmdValid), 1);
      @(negedge clk);
      check_eq("t3_drop", 32'(cmdValid), 0);
      wait_frame_done("t3");
      check_frame("t3", 8'h80);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmdValid && n < 10);
      check_eq("t3_pending_start", n, 3);
      wait_frame_done("t3p");
      strobe();
      // 4) watchdog
      for (int f = 0; f < 3; f++) wait_frame_done("t4");
      @(negedge clk);
      check_eq("t4_fs_pre", 32'(failsafe), 0);
      wait_frame_done("t4");
      @(negedge clk);
      check_eq("t4_fs", 32'(failsafe), 1);
      log_clear();
      wait_frame_done("t4z");
      check_frame("t4_zero", 8'h00);
      targetSpeedFlat = {8{8'h85}};
      strobe();
      check_eq("t4_fs_clr", 32'(failsafe), 0);
      log_clear();
      wait_frame_done("t4l");
      check_frame("t4_live", 8'h85);
      strobe();
      // masterEnable dropped during motor 2
      log_clear();
      wait_valid("en", 7'h2B);
      masterEnable = 1'b0;
      n = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (frameDone) n++;
      end
      check_eq("en_no_done", n, 0);
      check_eq("en_writes", log_addr.size(), 3);
      check_eq("en_busy", 32'(busy), 0);
      masterEnable = 1'b1;
      // 5) reset during WAIT
      for (fr = 0; fr < 4; fr++) wait_frame_done("t5wd");
      @(negedge clk);
      check_eq("t5_fs_pre", 32'(failsafe), 1);
      nack_mask = 8'h01;
      log_clear();
      wait_valid("t5", 7'h2A);
      @(negedge clk);
      check_eq("t5_busy_pre", 32'(busy), 1);
      check_eq("t5_nack_pre", 32'(nackFlags), 32'h01);
      rst_n = 1'b0;
      #1;
      check_eq("t5_valid", 32'(cmdValid), 0);
      check_eq("t5_busy", 32'(busy), 0);
      check_eq("t5_nack", 32'(nackFlags), 0);
      check_eq("t5_fs", 32'(failsafe), 0);
      repeat (3) @(negedge clk);
      nack_mask = '0;
      rst_n = 1'b1;
      log_clear();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cmdValid && n < 200);
      check_eq("t5_first_frame", n, FT + 1);
      wait_frame_done("t5f");
      check_frame("t5_frame", 8'h85);
`endif
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
